// File: rtl/tpu_pkg.sv
// ============================================================================
// Module      : tpu_pkg
// Description : Shared TPU constants, FSM state type and custom opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tpu_pkg;

    localparam int DIM       = 8;
    localparam int DATA_W    = 32;
    localparam int MM_CYCLES = 3 * DIM - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tpu_state_e;

    // Custom-0 opcodes also decoded by the control unit
    localparam logic [6:0] c_opc_matmul = 7'h50;
    localparam logic [6:0] c_opc_lam    = 7'h51;
    localparam logic [6:0] c_opc_lbm    = 7'h52;
    localparam logic [6:0] c_opc_lacc   = 7'h53;
    localparam logic [6:0] c_opc_racc   = 7'h54;

endpackage

`default_nettype wire

// File: rtl/tpu_step_counter.sv
// ============================================================================
// Module      : tpu_step_counter
// Description : Matmul step counter with clear/enable and terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tpu_step_counter #(
    parameter int MM_CYCLES = tpu_pkg::MM_CYCLES,
    parameter int CNT_W     = $clog2(MM_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(MM_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;
    assign tc_o  = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/tpu_issue_ctrl.sv
// ============================================================================
// Module      : tpu_issue_ctrl
// Description : Issues decoded TPU commands, sequences matmul steps, stalls
//               decode while busy and serves racc with write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tpu_issue_ctrl #(
    parameter int DIM       = tpu_pkg::DIM,
    parameter int DATA_W    = tpu_pkg::DATA_W,
    parameter int IDX_W     = $clog2(DIM),
    parameter int MM_CYCLES = 3 * DIM - 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         tpu_start_i,
    input  logic                         tpu_write_enable_A_i,
    input  logic                         tpu_write_enable_B_i,
    input  logic                         tpu_write_enable_C_i,
    input  logic                         racc_i,
    input  logic                         flush_i,
    input  logic [IDX_W-1:0]             row_i,
    input  logic [IDX_W-1:0]             col_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic [DATA_W-1:0]            acc_rd_data_i,
    output logic                         tpu_we_a_o,
    output logic                         tpu_we_b_o,
    output logic                         tpu_we_c_o,
    output logic [IDX_W-1:0]             tpu_row_o,
    output logic [IDX_W-1:0]             tpu_col_o,
    output logic [DATA_W-1:0]            tpu_wdata_o,
    output logic                         tpu_step_o,
    output logic                         tpu_done_o,
    output logic [$clog2(MM_CYCLES)-1:0] step_cnt_o,
    output logic [IDX_W-1:0]             acc_rd_row_o,
    output logic [IDX_W-1:0]             acc_rd_col_o,
    output logic [DATA_W-1:0]            racc_data_o,
    output logic                         busy_o,
    output logic                         stall_o
);

    import tpu_pkg::*;

    localparam int CNT_W = $clog2(MM_CYCLES);

    tpu_state_e        r_state;
    logic              r_busy;
    logic              r_step;
    logic              r_done;
    logic              r_we_a;
    logic              r_we_b;
    logic              r_we_c;
    logic [IDX_W-1:0]  r_row;
    logic [IDX_W-1:0]  r_col;
    logic [DATA_W-1:0] r_wdata;

    logic              w_any_cmd;
    logic              w_stall;
    logic              w_ok;
    logic              w_acc_start;
    logic              w_acc_a;
    logic              w_acc_b;
    logic              w_acc_c;
    logic              w_cnt_en;
    logic              w_cnt_clr;
    logic              w_tc;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_fwd;

    assign w_any_cmd = tpu_start_i | tpu_write_enable_A_i | tpu_write_enable_B_i
                     | tpu_write_enable_C_i | racc_i;
    assign w_stall   = r_busy & ~flush_i & w_any_cmd;
    assign w_ok      = ~flush_i & ~w_stall;

    // Decode should present one strobe at most; priority resolves any overlap
    assign w_acc_start = w_ok & tpu_start_i;
    assign w_acc_a     = w_ok & ~tpu_start_i & tpu_write_enable_A_i;
    assign w_acc_b     = w_ok & ~tpu_start_i & ~tpu_write_enable_A_i & tpu_write_enable_B_i;
    assign w_acc_c     = w_ok & ~tpu_start_i & ~tpu_write_enable_A_i & ~tpu_write_enable_B_i
                       & tpu_write_enable_C_i;

    assign w_cnt_en  = (r_state == RUN);
    assign w_cnt_clr = (r_state != RUN) | w_tc;

    tpu_step_counter #(
        .MM_CYCLES (MM_CYCLES),
        .CNT_W     (CNT_W)
    ) u_step_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_cnt_clr),
        .en_i  (w_cnt_en),
        .cnt_o (w_cnt),
        .tc_o  (w_tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_tc) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_step  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (w_acc_start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_step  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_step  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we_a  <= 1'b0;
            r_we_b  <= 1'b0;
            r_we_c  <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_wdata <= '0;
        end else begin
            r_we_a <= w_acc_a;
            r_we_b <= w_acc_b;
            r_we_c <= w_acc_c;
            if (w_acc_a | w_acc_b | w_acc_c) begin
                r_row   <= row_i;
                r_col   <= col_i;
                r_wdata <= data_i;
            end
        end
    end

    // A lacc still in the write register is newer than the array contents
    assign w_fwd = r_we_c & (r_row == row_i) & (r_col == col_i);

    assign acc_rd_row_o = row_i;
    assign acc_rd_col_o = col_i;
    assign racc_data_o  = w_fwd ? r_wdata : acc_rd_data_i;

    assign tpu_we_a_o  = r_we_a;
    assign tpu_we_b_o  = r_we_b;
    assign tpu_we_c_o  = r_we_c;
    assign tpu_row_o   = r_row;
    assign tpu_col_o   = r_col;
    assign tpu_wdata_o = r_wdata;
    assign tpu_step_o  = r_step;
    assign tpu_done_o  = r_done;
    assign step_cnt_o  = w_cnt;
    assign busy_o      = r_busy;
    assign stall_o     = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_tpu_issue_ctrl.sv
// ============================================================================
// Module      : tb_tpu_issue_ctrl
// Description : Self-checking bench for tpu_issue_ctrl against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tpu_issue_ctrl;

    localparam int DIM    = 8;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;
    localparam int MM     = 22;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, we_a, we_b, we_c, racc, flush;
    logic [IDX_W-1:0]  row, col;
    logic [DATA_W-1:0] data, acc_rd;

    logic              tpu_we_a_o, tpu_we_b_o, tpu_we_c_o;
    logic [IDX_W-1:0]  tpu_row_o, tpu_col_o, acc_rd_row_o, acc_rd_col_o;
    logic [DATA_W-1:0] tpu_wdata_o, racc_data_o;
    logic              tpu_step_o, tpu_done_o, busy_o, stall_o;
    logic [CNT_W-1:0]  step_cnt_o;

    tpu_issue_ctrl #(.DIM(DIM), .DATA_W(DATA_W), .IDX_W(IDX_W), .MM_CYCLES(MM)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .tpu_start_i          (start),
        .tpu_write_enable_A_i (we_a),
        .tpu_write_enable_B_i (we_b),
        .tpu_write_enable_C_i (we_c),
        .racc_i               (racc),
        .flush_i              (flush),
        .row_i                (row),
        .col_i                (col),
        .data_i               (data),
        .acc_rd_data_i        (acc_rd),
        .tpu_we_a_o           (tpu_we_a_o),
        .tpu_we_b_o           (tpu_we_b_o),
        .tpu_we_c_o           (tpu_we_c_o),
        .tpu_row_o            (tpu_row_o),
        .tpu_col_o            (tpu_col_o),
        .tpu_wdata_o          (tpu_wdata_o),
        .tpu_step_o           (tpu_step_o),
        .tpu_done_o           (tpu_done_o),
        .step_cnt_o           (step_cnt_o),
        .acc_rd_row_o         (acc_rd_row_o),
        .acc_rd_col_o         (acc_rd_col_o),
        .racc_data_o          (racc_data_o),
        .busy_o               (busy_o),
        .stall_o              (stall_o)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_left = matmul steps still to issue; everything else follows from it
    int                m_left;
    logic              m_done, m_we_a, m_we_b, m_we_c;
    logic [IDX_W-1:0]  m_row, m_col;
    logic [DATA_W-1:0] m_wdata;
    logic              m_any, m_stall, m_ok, m_start, m_a, m_b, m_c;
    logic [DATA_W-1:0] m_racc;

    always_comb begin
        m_any   = start | we_a | we_b | we_c | racc;
        m_stall = (m_left > 0) && !flush && m_any;
        m_ok    = !flush && !m_stall;
        m_start = m_ok && start;
        m_a     = m_ok && !start && we_a;
        m_b     = m_ok && !start && !we_a && we_b;
        m_c     = m_ok && !start && !we_a && !we_b && we_c;
        m_racc  = (m_we_c && m_row == row && m_col == col) ? m_wdata : acc_rd;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_we_a  <= 1'b0;
            m_we_b  <= 1'b0;
            m_we_c  <= 1'b0;
            m_row   <= '0;
            m_col   <= '0;
            m_wdata <= '0;
        end else begin
            m_done <= (m_left == 1);
            if (m_left > 0)   m_left <= m_left - 1;
            else if (m_start) m_left <= MM;
            m_we_a <= m_a;
            m_we_b <= m_b;
            m_we_c <= m_c;
            if (m_a || m_b || m_c) begin
                m_row   <= row;
                m_col   <= col;
                m_wdata <= data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("step",     64'(tpu_step_o), 64'(m_left > 0));
            check("busy",     64'(busy_o),     64'(m_left > 0));
            check("done",     64'(tpu_done_o), 64'(m_done));
            check("step_cnt", 64'(step_cnt_o), 64'((m_left > 0) ? (MM - m_left) : 0));
            check("we_a",     64'(tpu_we_a_o), 64'(m_we_a));
            check("we_b",     64'(tpu_we_b_o), 64'(m_we_b));
            check("we_c",     64'(tpu_we_c_o), 64'(m_we_c));
            check("stall",    64'(stall_o),    64'(m_stall));
            check("racc",     64'(racc_data_o), 64'(m_racc));
            check("rd_row",   64'(acc_rd_row_o), 64'(row));
            check("rd_col",   64'(acc_rd_col_o), 64'(col));
            if (m_we_a || m_we_b || m_we_c) begin
                check("wr_row",  64'(tpu_row_o),   64'(m_row));
                check("wr_col",  64'(tpu_col_o),   64'(m_col));
                check("wr_data", 64'(tpu_wdata_o), 64'(m_wdata));
            end
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        start = 0; we_a = 0; we_b = 0; we_c = 0; racc = 0; flush = 0;
        row = '0; col = '0; data = '0; acc_rd = '0;
    endtask

    task automatic rand_in();
        int r;
        r = $urandom_range(0, 99);
        start = (r < 4);
        we_a  = (r >= 4  && r < 14);
        we_b  = (r >= 14 && r < 24);
        we_c  = (r >= 24 && r < 34);
        racc  = (r >= 34 && r < 44);
        if ($urandom_range(0, 19) == 0) {start, we_a, we_b, we_c, racc} = 5'($urandom);
        flush = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 1) begin
            row = IDX_W'($urandom);
            col = IDX_W'($urandom);
        end
        data   = $urandom;
        acc_rd = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_step"},  64'(tpu_step_o), 64'(0));
        check({tag, "_busy"},  64'(busy_o),     64'(0));
        check({tag, "_done"},  64'(tpu_done_o), 64'(0));
        check({tag, "_cnt"},   64'(step_cnt_o), 64'(0));
        check({tag, "_we"},    64'({tpu_we_a_o, tpu_we_b_o, tpu_we_c_o}), 64'(0));
        check({tag, "_wregs"}, 64'({tpu_row_o, tpu_col_o, tpu_wdata_o}), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // Single lam
        step_cyc(); we_a = 1; row = 3'd2; col = 3'd5; data = 32'hDEADBEEF;
        step_cyc(); clear_in();
        @(negedge clk);
        check("lam_we_a",  64'(tpu_we_a_o),  64'(1));
        check("lam_row",   64'(tpu_row_o),   64'(2));
        check("lam_col",   64'(tpu_col_o),   64'(5));
        check("lam_data",  64'(tpu_wdata_o), 64'hDEADBEEF);
        check("lam_we_bc", 64'({tpu_we_b_o, tpu_we_c_o}), 64'(0));
        step_cyc();
        @(negedge clk);
        check("lam_we_a_off", 64'(tpu_we_a_o), 64'(0));

        // Matmul with lbm held from T+5, flushed at T+7
        step_cyc(); start = 1;
        step_cyc(); start = 0;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k <= 22) begin
                check("mm_step",  64'(tpu_step_o), 64'(1));
                check("mm_cnt",   64'(step_cnt_o), 64'(k - 1));
                check("mm_busy",  64'(busy_o),     64'(1));
                check("mm_done",  64'(tpu_done_o), 64'(0));
                check("mm_stall", 64'(stall_o),    64'(k >= 5 && k != 7));
                check("mm_we_b",  64'(tpu_we_b_o), 64'(0));
            end else begin
                check("mm_done_pulse", 64'(tpu_done_o), 64'(1));
                check("mm_busy_off",   64'(busy_o),     64'(0));
                check("mm_step_off",   64'(tpu_step_o), 64'(0));
                check("mm_stall_off",  64'(stall_o),    64'(0));
            end
            step_cyc();
            we_b  = (k + 1 >= 5 && k + 1 <= 23);
            flush = (k + 1 == 7);
            row = 3'd3; col = 3'd4; data = 32'h00000B0B;
        end
        @(negedge clk);
        check("lbm_we_b", 64'(tpu_we_b_o),  64'(1));
        check("lbm_done", 64'(tpu_done_o),  64'(0));
        check("lbm_data", 64'(tpu_wdata_o), 64'h0B0B);

        // lacc then racc forwarding
        step_cyc(); clear_in(); we_c = 1; row = 3'd1; col = 3'd1; data = 32'h1234;
        step_cyc(); clear_in(); racc = 1; row = 3'd1; col = 3'd1; acc_rd = 32'hAAAA5555;
        @(negedge clk);
        check("fwd_hit", 64'(racc_data_o), 64'h1234);
        #1 col = 3'd2;
        #1;
        check("fwd_miss", 64'(racc_data_o),  64'hAAAA5555);
        check("rd_col_2", 64'(acc_rd_col_o), 64'(2));

        // Reset in the middle of a matmul
        step_cyc(); clear_in(); start = 1;
        step_cyc(); start = 0;
        repeat (9) step_cyc();
        @(negedge clk);
        check("mid_step", 64'(tpu_step_o), 64'(1));
        check("mid_cnt",  64'(step_cnt_o), 64'(9));
        #1 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #1 rst = 1'b0;
        step_cyc(); start = 1; flush = 1;
        step_cyc(); clear_in();
        @(negedge clk);
        check("flushed_mm_busy", 64'(busy_o),     64'(0));
        check("flushed_mm_step", 64'(tpu_step_o), 64'(0));

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            step_cyc();
            rand_in();
            if (i % 1000 == 500) begin
                #1 rst = 1'b1;
                #1;
                check_all_zero("rand_rst");
                @(negedge clk);
                #3 rst = 1'b0;
            end
        end

        step_cyc();
        clear_in();
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
